mem_port_arbiter: RTL

- Shares one single-port synchronous block RAM between the processor's instruction-fetch port and its data port.
- Each requester keeps its existing request/ready handshake; the arbiter serialises the accesses.
- Grants alternate round-robin when both ports request at once, so a one-port memory can replace the dual-port adapter.
- Sits between the Processor core and the memory, in the same clock domain as the core.

---
 rtl/mem_port_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous RAM between an instruction-fetch port and
// a data port. Accesses are serialised as IDLE -> ISSUE -> WAIT (MEM_LATENCY
// cycles) -> RESP. Simultaneous requests are granted round-robin, and every
// value driven toward the memory or back to a requester is registered.
module mem_port_arbiter #(
  parameter int ADDR_W      = 30,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_read,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [31:0]       inst_dout,
  output logic              inst_ready,
  input  logic              data_read,
  input  logic [3:0]        data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_din,
  output logic [31:0]       data_dout,
  output logic              data_ready,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout,
  output logic              busy,
  output logic              grant_data
);

  // Handshake: a port requests by holding inst_read (data port: data_read or
  // nonzero data_we) high with stable address/data. The arbiter answers with a
  // single-cycle *_ready pulse once the access is finished and that port's dout
  // register holds the read word. The requester drops its request in the cycle
  // after it samples ready; a request still high when the arbiter is back in
  // IDLE is a new transaction. Requests are only looked at in IDLE.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LATENCY);

  state_t     state;       // current FSM state, kept visible for debug
  logic       last_grant;  // 1 = data owned the previous grant
  logic       is_write;    // latched access type of the current transaction
  logic [2:0] wait_cnt;    // remaining WAIT cycles, last one at value 1

  logic inst_req;
  logic data_req;
  logic pick_data;

  // Decode the two requests and choose the winner for a grant taken in IDLE.
  always_comb begin
    inst_req  = inst_read;
    data_req  = data_read | (data_we != 4'd0);
    pick_data = 1'b0;
    if (data_req && (!inst_req || !last_grant)) begin
      pick_data = 1'b1;
    end
  end

  // Arbitration FSM: latches the winning access, strobes the RAM for one
  // cycle, waits out the RAM latency, then returns the word with a ready pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      is_write   <= 1'b0;
      wait_cnt   <= 3'd0;
      inst_dout  <= 32'd0;
      inst_ready <= 1'b0;
      data_dout  <= 32'd0;
      data_ready <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 4'd0;
      mem_addr   <= '0;
      mem_din    <= 32'd0;
      busy       <= 1'b0;
      grant_data <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            grant_data <= pick_data;
            last_grant <= pick_data;
            is_write   <= pick_data && (data_we != 4'd0);
            mem_addr   <= pick_data ? data_addr : inst_addr;
            mem_din    <= pick_data ? data_din : 32'd0;
            mem_we     <= pick_data ? data_we : 4'd0;
            mem_en     <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en   <= 1'b0;
          mem_we   <= 4'd0;
          wait_cnt <= LAT;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd1) begin
            if (!is_write) begin
              if (grant_data) begin
                data_dout <= mem_dout;
              end else begin
                inst_dout <= mem_dout;
              end
            end
            if (grant_data) begin
              data_ready <= 1'b1;
            end else begin
              inst_ready <= 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          inst_ready <= 1'b0;
          data_ready <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
